// File: rtl/temp_sample_logger.sv
// Stream-to-RAM write engine: packs pairs of 16-bit temperature samples into 32-bit words
// and writes them into a RAM window as a linear (stop when full) or ring buffer.
module temp_sample_logger #(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              wrap_en,
    input  logic              snk_valid,
    input  logic [15:0]       snk_data,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [31:0]       word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              snk_ready_q, snk_ready_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic              mem_write_q, mem_write_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]       count_q, count_d;
    logic              half_q, half_d;
    logic [15:0]       low_q, low_d;
    logic              wrap_q, wrap_d;

    logic accept_c;
    logic pair_wr_c;
    logic flush_wr_c;
    logic full_hit_c;
    logic last_c;

    assign accept_c   = snk_valid & snk_ready_q;
    assign pair_wr_c  = accept_c & half_q;
    assign last_c     = (wr_ptr_q == LAST);
    assign full_hit_c = pair_wr_c & last_c & ~wrap_q;
    // A stop with exactly one half-word outstanding (held or arriving now) needs a partial write.
    assign flush_wr_c = (state_q == S_RUN) & stop & (half_q ^ accept_c);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (full_hit_c)  state_d = S_DONE;
                else if (stop)   state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        snk_ready_d   = (state_d == S_RUN);
        busy_d        = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d        = (state_d == S_DONE);
        mem_address_d = mem_address_q;
        mem_be_d      = 4'b0000;
        mem_write_d   = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        wrapped_d     = wrapped_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        half_d        = half_q;
        low_d         = low_q;
        wrap_d        = wrap_q;

        if ((state_q == S_IDLE || state_q == S_DONE) && start) begin
            wr_ptr_d  = BASE;
            count_d   = 32'd0;
            wrapped_d = 1'b0;
            half_d    = 1'b0;
            wrap_d    = wrap_en;
        end else if (state_q == S_RUN) begin
            if (accept_c && !half_q) begin
                low_d  = snk_data;
                half_d = 1'b1;
            end
            if (pair_wr_c || flush_wr_c) begin
                mem_write_d   = 1'b1;
                mem_address_d = wr_ptr_q;
                if (pair_wr_c) begin
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = {snk_data, low_q};
                end else begin
                    mem_be_d    = 4'b0011;
                    mem_wdata_d = {16'h0000, (half_q ? low_q : snk_data)};
                end
                if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
                if (last_c && wrap_q) begin
                    wr_ptr_d  = BASE;
                    wrapped_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                half_d = 1'b0;
            end
            if (stop) half_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            snk_ready_q   <= 1'b0;
            mem_address_q <= BASE;
            mem_be_q      <= 4'b0000;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wrapped_q     <= 1'b0;
            wr_ptr_q      <= BASE;
            count_q       <= 32'd0;
            half_q        <= 1'b0;
            low_q         <= 16'h0000;
            wrap_q        <= 1'b0;
        end else begin
            snk_ready_q   <= snk_ready_d;
            mem_address_q <= mem_address_d;
            mem_be_q      <= mem_be_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wrapped_q     <= wrapped_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            half_q        <= half_d;
            low_q         <= low_d;
            wrap_q        <= wrap_d;
        end
    end

    assign snk_ready      = snk_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_be_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_clken      = 1'b1;
    assign busy           = busy_q;
    assign done           = done_q;
    assign wrapped        = wrapped_q;
    assign wr_ptr         = wr_ptr_q;
    assign word_count     = count_q;

endmodule

// File: tb/tb_temp_sample_logger.sv
// Directed bench for temp_sample_logger: a reference model predicts every RAM write into a
// scoreboard queue, and a negedge monitor pops and compares each write the DUT issues.
module tb_temp_sample_logger;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned BASE_ADDR = 8;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned LAST      = BASE_ADDR + DEPTH - 1;

    logic              clk = 1'b0;
    logic              reset, start, stop, wrap_en, snk_valid;
    logic [15:0]       snk_data;
    logic              snk_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic              busy, done, wrapped;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       word_count;

    temp_sample_logger #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .wrap_en(wrap_en),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy), .done(done),
        .wrapped(wrapped), .wr_ptr(wr_ptr), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [3:0]        be;
        logic [31:0]       d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Reference model state
    logic        m_ready, m_half, m_wrap, m_wrapped;
    logic [15:0] m_low;
    int unsigned m_ptr, m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [3:0] be, input logic [31:0] d);
        wr_t w;
        w.a = ADDR_W'(m_ptr);
        w.be = be;
        w.d = d;
        exp_q.push_back(w);
        m_count++;
        if (m_ptr == LAST) begin
            if (m_wrap) begin
                m_ptr = BASE_ADDR;
                m_wrapped = 1'b1;
            end else begin
                m_ptr = m_ptr + 1;
                m_ready = 1'b0;
            end
        end else begin
            m_ptr = m_ptr + 1;
        end
    endtask

    task automatic do_start(input logic w);
        start = 1'b1;
        wrap_en = w;
        tick();
        start = 1'b0;
        m_ptr = BASE_ADDR; m_count = 0; m_wrapped = 1'b0;
        m_half = 1'b0; m_wrap = w; m_ready = 1'b1;
        check("ready_after_start", 32'(snk_ready), 32'd1);
    endtask

    // Offer one sample (optionally with stop in the same cycle); valid left asserted.
    task automatic send(input logic [15:0] data, input logic with_stop);
        logic r;
        snk_valid = 1'b1;
        snk_data = data;
        stop = with_stop;
        check("snk_ready", 32'(snk_ready), 32'(m_ready));
        r = m_ready;
        if (r) begin
            if (m_half) begin
                model_write(4'b1111, {data, m_low});
                m_half = 1'b0;
            end else begin
                m_low = data;
                m_half = 1'b1;
            end
        end
        if (with_stop && r && m_ready) begin
            if (m_half) model_write(4'b0011, {16'h0000, m_low});
            m_half = 1'b0;
            m_ready = 1'b0;
        end
        tick();
        stop = 1'b0;
    endtask

    task automatic do_stop();
        snk_valid = 1'b0;
        stop = 1'b1;
        if (m_ready) begin
            if (m_half) model_write(4'b0011, {16'h0000, m_low});
            m_half = 1'b0;
            m_ready = 1'b0;
        end
        tick();
        stop = 1'b0;
    endtask

    // Write monitor: every DUT write must match the oldest predicted write
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            wr_t w;
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed addr %h be %h data %h expected none",
                       mem_address, mem_byteenable, mem_writedata);
            end
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(mem_address), 32'(w.a));
                check("wr_be", 32'(mem_byteenable), 32'(w.be));
                check("wr_data", mem_writedata, w.d);
                check("wr_cs", 32'(mem_chipselect), 32'd1);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(snk_ready), 32'd0);
        check({tag, "_write"}, 32'(mem_write), 32'd0);
        check({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
        check({tag, "_be"}, 32'(mem_byteenable), 32'd0);
        check({tag, "_addr"}, 32'(mem_address), BASE_ADDR);
        check({tag, "_wdata"}, mem_writedata, 32'd0);
        check({tag, "_wrapped"}, 32'(wrapped), 32'd0);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), BASE_ADDR);
        check({tag, "_count"}, word_count, 32'd0);
        check({tag, "_clken"}, 32'(mem_clken), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; wrap_en = 1'b0;
        snk_valid = 1'b0; snk_data = 16'h0000;
        m_ready = 1'b0; m_half = 1'b0; m_wrap = 1'b0; m_wrapped = 1'b0;
        m_low = 16'h0000; m_ptr = BASE_ADDR; m_count = 0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check_reset_vals("reset");

        // T1: single full word
        do_start(1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        snk_valid = 1'b0;
        check("t1_wr_ptr", 32'(wr_ptr), BASE_ADDR + 1);
        check("t1_count", word_count, 32'd1);
        tick();
        do_stop();
        tick();
        check("t1_done", 32'(done), 32'd1);

        // T2: odd sample count flushed by stop
        do_start(1'b0);
        check("t2_restart_count", word_count, 32'd0);
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b0);
        send(16'hCCCC, 1'b0);
        do_stop();
        check("t2_busy_flush", 32'(busy), 32'd1);
        tick();
        check("t2_done", 32'(done), 32'd1);
        check("t2_count", word_count, 32'd2);
        check("t2_ready", 32'(snk_ready), 32'd0);
        check("t2_wr_ptr", 32'(wr_ptr), BASE_ADDR + 2);

        // T3: linear buffer fills and stops
        do_start(1'b0);
        for (int i = 0; i < 10; i++) send(16'(16'h3000 + i), 1'b0);
        snk_valid = 1'b0;
        tick();
        check("t3_done", 32'(done), 32'd1);
        check("t3_count", word_count, 32'd4);
        check("t3_wr_ptr", 32'(wr_ptr), BASE_ADDR + DEPTH);
        check("t3_wrapped", 32'(wrapped), 32'd0);

        // T4: ring buffer wraps back to BASE
        do_start(1'b1);
        for (int i = 0; i < 10; i++) send(16'(16'h4000 + i), 1'b0);
        snk_valid = 1'b0;
        tick();
        check("t4_wrapped", 32'(wrapped), 32'(m_wrapped));
        check("t4_wrapped_set", 32'(wrapped), 32'd1);
        check("t4_count", word_count, 32'd5);
        check("t4_wr_ptr", 32'(wr_ptr), 32'(m_ptr));
        check("t4_busy", 32'(busy), 32'd1);
        do_stop();
        tick();
        check("t4_done", 32'(done), 32'd1);

        // T5: stop coincident with the second sample of a pair
        do_start(1'b0);
        send(16'h5555, 1'b0);
        send(16'h6666, 1'b1);
        snk_valid = 1'b0;
        tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_count", word_count, 32'd1);

        // Stop alongside the first half-word flushes that sample as a partial word
        do_start(1'b0);
        send(16'h7777, 1'b1);
        snk_valid = 1'b0;
        tick();
        check("stop_first_count", word_count, 32'd1);
        check("stop_first_done", 32'(done), 32'd1);

        // T6: reset mid-run with a half-word pending
        do_start(1'b1);
        send(16'h8001, 1'b0);
        send(16'h8002, 1'b0);
        send(16'h8003, 1'b0);
        snk_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("t6");
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_busy", 32'(busy), 32'd0);
        check("idle_stop_done", 32'(done), 32'd0);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
